fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the 16-bit sync FIFO (wr/din/full/almostfull/over) between two producers.
- Each producer uses a valid/ready handshake; arbitration is round-robin with a bounded burst length.
- Drives registered fifo_wr/fifo_din, so FIFO writes occur one cycle after handshake acceptance.
- Prevents FIFO overflow, latches a sticky overflow error, and counts words written.

Parameters:
- DW, 16, data width; matches FIFO din width.
- BURST, 4, max consecutive words granted to one requester while the other waits (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-low reset.
- req0_valid  in  1  producer 0 has a word.
- req0_data  in  DW  producer 0 word.
- req0_ready  out  1  producer 0 word accepted this cycle when high with valid.
- req1_valid  in  1  producer 1 has a word.
- req1_data  in  DW  producer 1 word.
- req1_ready  out  1  producer 1 accept.
- fifo_full  in  1  FIFO full.
- fifo_almostfull  in  1  FIFO has at most one free slot.
- fifo_over  in  1  FIFO write-while-full indication.
- fifo_wr  out  1  registered FIFO write strobe.
- fifo_din  out  DW  registered FIFO write data.
- grant  out  2  one-hot current owner; 00 when idle.
- err_over  out  1  sticky overflow error.
- wcount  out  16  words written to FIFO, wraps at 65535->0.

Behaviour:
- Reset (rst==0 at a clk edge):
  - fifo_wr=0, fifo_din=0, grant=00, err_over=0, wcount=0, burst counter=0.
  - State=IDLE; round-robin pointer favours requester 0.
  - Applies even mid-burst; any word accepted in that same cycle is dropped.
- FSM states: IDLE, G0, G1.
  - IDLE: if exactly one valid, go to that Gx. If both valid, go to Gx per the pointer. Burst counter cleared. No accept in IDLE; the grant takes one cycle.
  - Gx: readyx = !fifo_full && !(fifo_almostfull && fifo_wr). The other ready is 0.
  - Accept = validx && readyx. On accept: fifo_wr<=1, fifo_din<=datax, burst counter+1. Otherwise fifo_wr<=0.
  - Leave Gx when validx==0, or when burst counter reaches BURST on an accept. Ties in that cycle resolve as "reached BURST".
  - On leaving: pointer<=other requester. If the other is valid, go directly to G(other) with counter=0, no idle cycle. Otherwise, if validx is still high, stay in Gx with counter=0. Otherwise go to IDLE.
- Backpressure while granted: readyx low, grant held, burst counter frozen. Full never forces a grant switch.
- Flow-control rule: data accepted at edge t is written at edge t+1.
  - almostfull with an in-flight write means no slot remains.
  - A correctly connected FIFO never sees wr while full.
- err_over: set on any cycle with fifo_over==1; cleared only by reset.
- wcount: increments on every cycle with fifo_wr==1.
- grant: reflects the FSM state (G0=01, G1=10, IDLE=00).
- Sustained throughput: 1 word/cycle while not near full.

Decomposition:
- Shared package fifo_pkg:
  - FSM state encoding (IDLE=2'd0, G0=2'd1, G1=2'd2).
  - Default DW=16, default BURST=4.
  - FIFO flag semantics as named constants: ALMOSTFULL_MARGIN=1.
- One natural sub-module, rr_ptr_burst: burst counter plus round-robin pointer with switch/hold decision. The top level holds the FSM, ready logic and output registers.

Test Plan:
- Only req0 valid, data 1..9, FIFO depth 16 with no reads -> 9 FIFO writes of 1..9, each one cycle after its accept; wcount=9; grant=01 throughout; err_over=0.
- Both valid continuously, req0 data 0x0A0x, req1 data 0x0B0x, BURST=4 -> FIFO order A0..A3, B0..B3, A4..A7; no idle cycle at switches; readys never both high.
- Depth-8 FIFO, no reads, req0 streams 12 words -> exactly 8 writes; req0_ready low from the cycle almostfull coincides with fifo_wr; fifo_over never asserted; grant stays 01.
- Force fifo_over=1 for one cycle -> err_over=1 from the next cycle and stays 1 until rst=0.
- Assert rst=0 during the 3rd word of a req1 burst -> next cycle fifo_wr=0, grant=00, wcount=0. After release with both valid, req0 is granted first.
- req0 drops valid after 2 words while req1 is valid -> switch to G1 the next cycle; req1 receives a full burst of 4.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
// State encoding, default widths and the grant mapping used by the top level.
package fifo_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StG0   = 2'd1,
    StG1   = 2'd2
  } arb_state_e;

  localparam int unsigned DefaultDw        = 16;
  localparam int unsigned DefaultBurst     = 4;
  localparam int unsigned AlmostFullMargin = 1;
  localparam int unsigned BurstCntW        = 8;

  function automatic logic [1:0] grant_of(arb_state_e st);
    case (st)
      StG0:    return 2'b01;
      StG1:    return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/rr_ptr_burst.sv
// Burst counter and round-robin pointer for the write-port arbiter.
// Decides when the current owner must give up the grant.
module rr_ptr_burst
  import fifo_pkg::*;
#(
  parameter int unsigned BURST = DefaultBurst
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic owner,
  input  logic accept,
  input  logic own_valid,
  output logic leave,
  output logic ptr
);

  logic [BurstCntW-1:0] cnt_q, cnt_d;
  logic [BurstCntW:0]   cnt_inc;
  logic                 ptr_q, ptr_d;
  logic                 hit;

  always_comb begin
    cnt_inc = {1'b0, cnt_q} + {{BurstCntW{1'b0}}, 1'b1};
    hit     = accept && (cnt_inc == (BurstCntW + 1)'(BURST));
    leave   = active && (!own_valid || hit);
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    if (!active) begin
      cnt_d = '0;
    end else if (leave) begin
      // Burst exhausted or owner idle: hand priority to the other requester.
      cnt_d = '0;
      ptr_d = !owner;
    end else if (accept) begin
      cnt_d = cnt_inc[BurstCntW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      ptr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Two-producer round-robin arbiter for the single write port of the sync FIFO.
// Registered write strobe/data, overflow-safe ready, sticky overflow flag and a write counter.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned DW    = DefaultDw,
  parameter int unsigned BURST = DefaultBurst
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  input  logic          fifo_full,
  input  logic          fifo_almostfull,
  input  logic          fifo_over,
  output logic          fifo_wr,
  output logic [DW-1:0] fifo_din,
  output logic [1:0]    grant,
  output logic          err_over,
  output logic [15:0]   wcount
);

  arb_state_e    state_q, state_d;
  logic          active, owner, own_valid, other_valid;
  logic          ready, accept, leave, ptr;
  logic [DW-1:0] own_data;

  rr_ptr_burst #(
    .BURST(BURST)
  ) u_rr (
    .clk      (clk),
    .rst      (rst),
    .active   (active),
    .owner    (owner),
    .accept   (accept),
    .own_valid(own_valid),
    .leave    (leave),
    .ptr      (ptr)
  );

  always_comb begin
    active      = (state_q != StIdle);
    owner       = (state_q == StG1);
    own_valid   = owner ? req1_valid : req0_valid;
    other_valid = owner ? req0_valid : req1_valid;
    own_data    = owner ? req1_data : req0_data;
    // A write already in flight consumes the last free slot signalled by almostfull.
    ready       = active && !fifo_full && !(fifo_almostfull && fifo_wr);
    accept      = own_valid && ready;
    req0_ready  = ready && !owner;
    req1_ready  = ready && owner;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req0_valid && req1_valid) begin
          state_d = ptr ? StG1 : StG0;
        end else if (req0_valid) begin
          state_d = StG0;
        end else if (req1_valid) begin
          state_d = StG1;
        end
      end
      StG0, StG1: begin
        if (leave) begin
          if (other_valid) begin
            state_d = owner ? StG0 : StG1;
          end else if (!own_valid) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      fifo_wr  <= 1'b0;
      fifo_din <= '0;
      grant    <= 2'b00;
      err_over <= 1'b0;
      wcount   <= '0;
    end else begin
      state_q <= state_d;
      grant   <= grant_of(state_d);
      fifo_wr <= accept;
      if (accept) begin
        fifo_din <= own_data;
      end
      if (fifo_over) begin
        err_over <= 1'b1;
      end
      if (fifo_wr) begin
        wcount <= wcount + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter with a behavioural FIFO that never reads.
module tb_fifo_wr_arbiter;
  import fifo_pkg::*;

  localparam int unsigned DW = 16;

  logic          clk;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          fifo_full, fifo_almostfull;
  logic          fifo_over;
  logic          fifo_wr;
  logic [DW-1:0] fifo_din;
  logic [1:0]    grant;
  logic          err_over;
  logic [15:0]   wcount;

  fifo_wr_arbiter #(
    .DW   (DW),
    .BURST(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req0_valid     (req0_valid),
    .req0_data      (req0_data),
    .req0_ready     (req0_ready),
    .req1_valid     (req1_valid),
    .req1_data      (req1_data),
    .req1_ready     (req1_ready),
    .fifo_full      (fifo_full),
    .fifo_almostfull(fifo_almostfull),
    .fifo_over      (fifo_over),
    .fifo_wr        (fifo_wr),
    .fifo_din       (fifo_din),
    .grant          (grant),
    .err_over       (err_over),
    .wcount         (wcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            vec  = 0;
  int            miss = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] src0[$];
  logic [DW-1:0] src1[$];
  int            wr_cyc[$];
  logic          en0, en1;
  int            depth  = 16;
  int            fcount = 0;
  logic          force_over = 1'b0;
  logic          allow_over = 1'b0;
  logic          hold_en    = 1'b0;
  logic [1:0]    hold_grant = 2'b00;
  logic          prev_acc, acc0, acc1, wr_s;
  int            cyc = 0;

  assign fifo_over = force_over | (fifo_wr & fifo_full);

  task automatic drive();
    req0_valid = en0 && (src0.size() > 0);
    req0_data  = (src0.size() > 0) ? src0[0] : '0;
    req1_valid = en1 && (src1.size() > 0);
    req1_data  = (src1.size() > 0) ? src1[0] : '0;
  endtask

  // Observe one cycle at the falling edge: scoreboard pops and protocol checks.
  task automatic sample();
    logic [DW-1:0] e;
    logic          r0, r1;
    @(negedge clk);
    cyc++;
    wr_s = fifo_wr;
    vec++;
    if (fifo_wr !== prev_acc) begin
      miss++;
      $display("FAIL wr_timing cyc=%0d: fifo_wr=%b, required %b", cyc, fifo_wr, prev_acc);
    end
    if (fifo_wr === 1'b1) begin
      wr_cyc.push_back(cyc);
      vec++;
      if (exp_q.size() == 0) begin
        miss++;
        $display("FAIL extra_write cyc=%0d: din=%h, no word expected", cyc, fifo_din);
      end else begin
        e = exp_q.pop_front();
        if (fifo_din !== e) begin
          miss++;
          $display("FAIL write_data cyc=%0d: din=%h, required %h", cyc, fifo_din, e);
        end
      end
      if (hold_en) begin
        vec++;
        if (grant !== hold_grant) begin
          miss++;
          $display("FAIL grant_hold cyc=%0d: grant=%b, required %b", cyc, grant, hold_grant);
        end
      end
    end
    r0 = (grant == 2'b01) && !fifo_full && !(fifo_almostfull && fifo_wr);
    r1 = (grant == 2'b10) && !fifo_full && !(fifo_almostfull && fifo_wr);
    vec++;
    if (req0_ready !== r0 || req1_ready !== r1) begin
      miss++;
      $display("FAIL ready cyc=%0d: ready=%b%b, required %b%b", cyc, req1_ready, req0_ready, r1,
               r0);
    end
    if (!allow_over) begin
      vec++;
      if (fifo_over !== 1'b0) begin
        miss++;
        $display("FAIL no_overflow cyc=%0d: fifo_over=%b, required 0", cyc, fifo_over);
      end
    end
    acc0 = req0_valid && req0_ready;
    acc1 = req1_valid && req1_ready;
  endtask

  // Cross the rising edge, update the FIFO model and the producers.
  task automatic advance();
    @(posedge clk);
    #1;
    if (wr_s && fcount < depth) fcount++;
    fifo_full       = (fcount >= depth);
    fifo_almostfull = (fcount >= int'(depth - AlmostFullMargin));
    prev_acc = rst ? (acc0 | acc1) : 1'b0;
    if (acc0) void'(src0.pop_front());
    if (acc1) void'(src1.pop_front());
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) begin
      sample();
      advance();
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    src0.delete(); src1.delete(); exp_q.delete(); wr_cyc.delete();
    en0 = 1'b0; en1 = 1'b0;
    force_over = 1'b0; allow_over = 1'b0; hold_en = 1'b0;
    fcount = 0; fifo_full = 1'b0; fifo_almostfull = 1'b0;
    prev_acc = 1'b0; acc0 = 1'b0; acc1 = 1'b0; wr_s = 1'b0;
    drive();
    @(posedge clk); #1;
    @(posedge clk); #1;
    vec++;
    if (fifo_wr !== 1'b0 || fifo_din !== '0 || grant !== 2'b00 || err_over !== 1'b0 ||
        wcount !== 16'd0) begin
      miss++;
      $display("FAIL reset_state: wr=%b din=%h grant=%b err=%b wcount=%0d, required all zero",
               fifo_wr, fifo_din, grant, err_over, wcount);
    end
    rst = 1'b1;
  endtask

  task automatic test_reset();
    depth = 16;
    apply_reset();
    run(3);
    vec++;
    if (grant !== 2'b00 || wcount !== 16'd0) begin
      miss++;
      $display("FAIL idle_after_reset: grant=%b wcount=%0d, required 00 and 0", grant, wcount);
    end
  endtask

  task automatic test_single_stream();
    depth = 16;
    apply_reset();
    for (int i = 1; i <= 9; i++) begin
      src0.push_back(DW'(i));
      exp_q.push_back(DW'(i));
    end
    en0 = 1'b1; hold_en = 1'b1; hold_grant = 2'b01;
    drive();
    run(20);
    vec++;
    if (wcount !== 16'd9 || wr_cyc.size() != 9 || exp_q.size() != 0) begin
      miss++;
      $display("FAIL single_count: wcount=%0d writes=%0d left=%0d, required 9 9 0", wcount,
               wr_cyc.size(), exp_q.size());
    end
    vec++;
    if (wr_cyc.size() == 9 && wr_cyc[8] - wr_cyc[0] != 8) begin
      miss++;
      $display("FAIL single_rate: span=%0d, required 8", wr_cyc[8] - wr_cyc[0]);
    end
    vec++;
    if (err_over !== 1'b0 || grant !== 2'b00) begin
      miss++;
      $display("FAIL single_end: err=%b grant=%b, required 0 and 00", err_over, grant);
    end
  endtask

  task automatic test_round_robin();
    depth = 64;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      src0.push_back(16'h0A00 + 16'(i));
      src1.push_back(16'h0B00 + 16'(i));
    end
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(((i / 4) % 2 == 0) ? 16'h0A00 + 16'((i / 8) * 4 + i % 4)
                                         : 16'h0B00 + 16'((i / 8) * 4 + i % 4));
    end
    en0 = 1'b1; en1 = 1'b1;
    drive();
    run(30);
    vec++;
    if (wr_cyc.size() != 16 || exp_q.size() != 0 || wcount !== 16'd16) begin
      miss++;
      $display("FAIL rr_count: writes=%0d left=%0d wcount=%0d, required 16 0 16", wr_cyc.size(),
               exp_q.size(), wcount);
    end
    vec++;
    if (wr_cyc.size() == 16 && wr_cyc[15] - wr_cyc[0] != 15) begin
      miss++;
      $display("FAIL rr_no_gap: span=%0d, required 15", wr_cyc[15] - wr_cyc[0]);
    end
  endtask

  task automatic test_full_stop();
    depth = 8;
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      src0.push_back(16'h0C00 + 16'(i));
      if (i < 8) exp_q.push_back(16'h0C00 + 16'(i));
    end
    en0 = 1'b1; hold_en = 1'b1; hold_grant = 2'b01;
    drive();
    run(30);
    vec++;
    if (wr_cyc.size() != 8 || exp_q.size() != 0 || wcount !== 16'd8) begin
      miss++;
      $display("FAIL full_count: writes=%0d left=%0d wcount=%0d, required 8 0 8", wr_cyc.size(),
               exp_q.size(), wcount);
    end
    vec++;
    if (grant !== 2'b01 || req0_ready !== 1'b0 || req0_valid !== 1'b1 || err_over !== 1'b0) begin
      miss++;
      $display("FAIL full_hold: grant=%b ready=%b valid=%b err=%b, required 01 0 1 0", grant,
               req0_ready, req0_valid, err_over);
    end
  endtask

  task automatic test_overflow_flag();
    depth = 16;
    apply_reset();
    allow_over = 1'b1;
    force_over = 1'b1;
    sample();
    advance();
    force_over = 1'b0;
    vec++;
    if (err_over !== 1'b1) begin
      miss++;
      $display("FAIL over_set: err_over=%b, required 1", err_over);
    end
    run(5);
    vec++;
    if (err_over !== 1'b1) begin
      miss++;
      $display("FAIL over_sticky: err_over=%b, required 1", err_over);
    end
    apply_reset();
  endtask

  task automatic test_reset_mid_burst();
    int   n1;
    logic hit;
    depth = 64;
    apply_reset();
    for (int i = 0; i < 8; i++) src1.push_back(16'h0D00 + 16'(i));
    exp_q.push_back(16'h0D00);
    exp_q.push_back(16'h0D01);
    en1 = 1'b1;
    drive();
    n1 = 0;
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      sample();
      if (acc1 && n1 == 2) begin
        rst = 1'b0;
        hit = 1'b1;
      end
      if (acc1) n1++;
      advance();
    end
    vec++;
    if (!hit) begin
      miss++;
      $display("FAIL mid_reset_timeout: accepted=%0d, required 3", n1);
    end
    vec++;
    if (fifo_wr !== 1'b0 || grant !== 2'b00 || wcount !== 16'd0 || exp_q.size() != 0) begin
      miss++;
      $display("FAIL mid_reset: wr=%b grant=%b wcount=%0d left=%0d, required 0 00 0 0", fifo_wr,
               grant, wcount, exp_q.size());
    end
    rst = 1'b1;
    src1.delete(); wr_cyc.delete();
    fcount = 0;
    for (int i = 0; i < 4; i++) begin
      src0.push_back(16'h0E00 + 16'(i));
      src1.push_back(16'h0F00 + 16'(i));
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(16'h0E00 + 16'(i));
    for (int i = 0; i < 4; i++) exp_q.push_back(16'h0F00 + 16'(i));
    en0 = 1'b1;
    drive();
    run(20);
    vec++;
    if (wr_cyc.size() != 8 || exp_q.size() != 0) begin
      miss++;
      $display("FAIL post_reset_order: writes=%0d left=%0d, required 8 0", wr_cyc.size(),
               exp_q.size());
    end
  endtask

  task automatic test_drop_switch();
    int   n0;
    logic a;
    depth = 64;
    apply_reset();
    for (int i = 0; i < 4; i++) src0.push_back(16'h0A10 + 16'(i));
    for (int i = 0; i < 6; i++) src1.push_back(16'h0B10 + 16'(i));
    exp_q = '{16'h0A10, 16'h0A11, 16'h0B10, 16'h0B11, 16'h0B12, 16'h0B13, 16'h0A12, 16'h0A13,
              16'h0B14, 16'h0B15};
    en0 = 1'b1; en1 = 1'b1;
    drive();
    n0 = 0;
    for (int k = 0; k < 20 && n0 < 2; k++) begin
      sample();
      a = acc0;
      advance();
      if (a) n0++;
    end
    en0 = 1'b0;
    drive();
    run(2);
    en0 = 1'b1;
    drive();
    run(25);
    vec++;
    if (wr_cyc.size() != 10 || exp_q.size() != 0 || wcount !== 16'd10) begin
      miss++;
      $display("FAIL drop_count: writes=%0d left=%0d wcount=%0d, required 10 0 10",
               wr_cyc.size(), exp_q.size(), wcount);
    end
    vec++;
    if (wr_cyc.size() >= 6 && (wr_cyc[2] - wr_cyc[1] != 2 || wr_cyc[5] - wr_cyc[2] != 3)) begin
      miss++;
      $display("FAIL drop_switch: gap=%0d burst_span=%0d, required 2 and 3",
               wr_cyc[2] - wr_cyc[1], wr_cyc[5] - wr_cyc[2]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    en0 = 1'b0; en1 = 1'b0;
    fifo_full = 1'b0; fifo_almostfull = 1'b0;
    drive();
    test_reset();
    test_single_stream();
    test_round_robin();
    test_full_stop();
    test_overflow_flag();
    test_reset_mid_burst();
    test_drop_switch();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
